init_table_sched: RTL and testbench

INIT_TABLE_SCHED -- requirements
Module: init_table_sched

---
 rtl/init_table_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/init_table_sched.sv | 131 +++++++++++++
 tb/tb_init_table_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/init_table_pkg.sv
// ============================================================================
// init_table_pkg : shared state encoding and default geometry for init_table_sched
// Rev 1.0
// ============================================================================
`default_nettype none

package init_table_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_NX   = 8;
    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : two-requester fair arbiter; on contention the side not granted last wins
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic REQ0,
    input  logic REQ1,
    input  logic enable,
    input  logic LAST,
    output logic GNT0,
    output logic GNT1
);

    // LAST=1 means requester 1 was granted most recently, so 0 wins a tie.
    always_comb begin
        GNT0 = enable & REQ0 & (~REQ1 | LAST);
        GNT1 = enable & REQ1 & (~REQ0 | ~LAST);
    end

endmodule

`default_nettype wire

// File: rtl/init_table_sched.sv
// ============================================================================
// init_table_sched : self-initialising table with host write port and two
//                    arbitrated 1-cycle-latency read ports
// Rev 1.0
// ============================================================================
`default_nettype none

module init_table_sched
    import init_table_pkg::*;
#(
    parameter int NX   = DEF_NX,
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    localparam int DEPTH = ROWS * COLS,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic [AW-1:0] ADDR0,
    input  logic          REQ1,
    input  logic [AW-1:0] ADDR1,
    output logic          GNT0,
    output logic          GNT1,
    output logic [NX-1:0] RDATA,
    output logic          RVALID,
    output logic          RID,
    input  logic          WEN,
    input  logic [AW-1:0] WADDR,
    input  logic [NX-1:0] WDATA,
    output logic          WACK,
    output logic          READY
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] cnt;
    logic [NX-1:0] mem [DEPTH];
    logic          last;
    logic          arb_en;
    logic          addr0_ok;
    logic          addr1_ok;
    logic          waddr_ok;
    logic [NX-1:0] rd0;
    logic [NX-1:0] rd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (cnt == LAST_IDX) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    always_comb begin
        READY  = (state == ST_RUN);
        WACK   = READY & WEN;
        arb_en = READY & ~WEN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + AW'(1);
        end
    end

    // Addresses beyond the populated table are dropped on write and read as zero.
    always_comb begin
        addr0_ok = (32'(ADDR0) < DEPTH);
        addr1_ok = (32'(ADDR1) < DEPTH);
        waddr_ok = (32'(WADDR) < DEPTH);
        rd0      = addr0_ok ? mem[ADDR0] : '0;
        rd1      = addr1_ok ? mem[ADDR1] : '0;
    end

    // No reset on the storage: the INIT sweep rewrites every entry after RST.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state == ST_INIT) begin
                mem[cnt] <= NX'(cnt);
            end else if (WEN && waddr_ok) begin
                mem[WADDR] <= WDATA;
            end
        end
    end

    rr_arb2 u_arb (
        .REQ0   (REQ0),
        .REQ1   (REQ1),
        .enable (arb_en),
        .LAST   (last),
        .GNT0   (GNT0),
        .GNT1   (GNT1)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            RVALID <= 1'b0;
            RID    <= 1'b0;
            RDATA  <= '0;
            last   <= 1'b1;
        end else begin
            RVALID <= GNT0 | GNT1;
            if (GNT0) begin
                RID   <= 1'b0;
                RDATA <= rd0;
                last  <= 1'b0;
            end else if (GNT1) begin
                RID   <= 1'b1;
                RDATA <= rd1;
                last  <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_init_table_sched.sv
// ============================================================================
// tb_init_table_sched : directed scenarios plus randomized traffic against a
//                       behavioural table/arbitration model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_init_table_sched;

    localparam int DEPTH = 16;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ0, REQ1, WEN;
    logic [3:0] ADDR0, ADDR1, WADDR;
    logic [7:0] WDATA;
    logic       GNT0, GNT1, RVALID, RID, WACK, READY;
    logic [7:0] RDATA;

    int checks = 0;
    int passed = 0;

    // Behavioural model
    bit         m_ready;
    int         m_cnt;
    logic [7:0] m_tbl [DEPTH];
    bit         m_last;
    bit         m_rvalid;
    bit         m_rid;
    logic [7:0] m_rdata;
    bit         e_g0, e_g1, e_wack;

    init_table_sched dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .ADDR0(ADDR0), .REQ1(REQ1), .ADDR1(ADDR1),
        .GNT0(GNT0), .GNT1(GNT1), .RDATA(RDATA), .RVALID(RVALID), .RID(RID),
        .WEN(WEN), .WADDR(WADDR), .WDATA(WDATA), .WACK(WACK), .READY(READY)
    );

    always #5 CLK = ~CLK;

    // Drive one cycle of inputs, settle to the falling edge, derive expected grants.
    task automatic apply(input bit rst, input bit r0, input logic [3:0] a0,
                         input bit r1, input logic [3:0] a1,
                         input bit w, input logic [3:0] wa, input logic [7:0] wd);
        RST = rst; REQ0 = r0; ADDR0 = a0; REQ1 = r1; ADDR1 = a1;
        WEN = w; WADDR = wa; WDATA = wd;
        @(negedge CLK);
        e_wack = m_ready && w;
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (m_ready && !w) begin
            if (r0 && r1) begin
                if (m_last) e_g0 = 1'b1;
                else        e_g1 = 1'b1;
            end else if (r0) begin
                e_g0 = 1'b1;
            end else if (r1) begin
                e_g1 = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST) begin
            m_ready = 1'b0; m_cnt = 0; m_last = 1'b1;
            m_rvalid = 1'b0; m_rid = 1'b0; m_rdata = 8'h00;
        end else if (!m_ready) begin
            m_tbl[m_cnt] = 8'(m_cnt);
            m_cnt++;
            if (m_cnt == DEPTH) m_ready = 1'b1;
        end else if (WEN) begin
            m_tbl[WADDR] = WDATA;
            m_rvalid = 1'b0;
        end else if (e_g0) begin
            m_rvalid = 1'b1; m_rid = 1'b0; m_rdata = m_tbl[ADDR0]; m_last = 1'b0;
        end else if (e_g1) begin
            m_rvalid = 1'b1; m_rid = 1'b1; m_rdata = m_tbl[ADDR1]; m_last = 1'b1;
        end else begin
            m_rvalid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply(1, 1, 4'd2, 1, 4'd3, 1, 4'd1, 8'h11);
        checks++;
        if ({READY, GNT0, GNT1, WACK} !== 4'b0000) $display("FAIL reset_ctrl: got %b expected 0000", {READY, GNT0, GNT1, WACK});
        else passed++;
        checks++;
        if ({RVALID, RID, RDATA} !== 10'd0) $display("FAIL reset_read: got rvalid=%b rid=%b rdata=%0h expected all 0", RVALID, RID, RDATA);
        else passed++;
        tick();
    endtask

    task automatic test_init_read();
        bit early = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            apply(0, 1, 4'd6, 0, 0, 0, 0, 0);
            if (READY !== 1'b0 || GNT0 !== 1'b0) early = 1'b1;
            tick();
        end
        checks++;
        if (early) $display("FAIL init_stall: READY/GNT0 high before edge 16, expected 0");
        else passed++;
        apply(0, 1, 4'd6, 0, 0, 0, 0, 0);
        checks++;
        if ({READY, GNT0} !== 2'b11) $display("FAIL init_ready_gnt: got %b expected 11", {READY, GNT0});
        else passed++;
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({RVALID, RID, RDATA} !== {1'b1, 1'b0, 8'd6}) $display("FAIL init_read: got rvalid=%b rid=%b rdata=%0h expected 1 0 6", RVALID, RID, RDATA);
        else passed++;
        tick();
    endtask

    task automatic test_alternate();
        logic [7:0] exp_data [4] = '{8'd5, 8'd9, 8'd5, 8'd9};
        apply(0, 0, 0, 1, 4'd1, 0, 0, 0);   // lone requester 1 grant leaves LAST=1
        tick();
        for (int i = 0; i < 5; i++) begin
            apply(0, i < 4, 4'd5, i < 4, 4'd9, 0, 0, 0);
            if (i < 4) begin
                checks++;
                if ({GNT0, GNT1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL alt_gnt[%0d]: got %b", i, {GNT0, GNT1});
                else passed++;
            end
            if (i > 0) begin
                checks++;
                if (RVALID !== 1'b1 || RDATA !== exp_data[i-1] || RID !== 1'((i - 1) % 2))
                    $display("FAIL alt_data[%0d]: got rdata=%0d rid=%b expected rdata=%0d rid=%0d", i - 1, RDATA, RID, exp_data[i-1], (i - 1) % 2);
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_write_priority();
        apply(0, 1, 4'd6, 0, 0, 1, 4'd6, 8'hAA);
        checks++;
        if ({WACK, GNT0} !== 2'b10) $display("FAIL wp_wack_gnt: got %b expected 10", {WACK, GNT0});
        else passed++;
        tick();
        apply(0, 1, 4'd6, 0, 0, 0, 0, 0);
        checks++;
        if (GNT0 !== 1'b1) $display("FAIL wp_gnt0: got %b expected 1", GNT0);
        else passed++;
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (RVALID !== 1'b1 || RDATA !== 8'hAA) $display("FAIL wp_raw: got rvalid=%b rdata=%0h expected 1 aa", RVALID, RDATA);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid_init();
        bit early = 1'b0;
        apply(0, 0, 0, 0, 0, 1, 4'd15, 8'hFF);
        tick();
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 1; k <= 7; k++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        apply(1, 0, 0, 0, 0, 0, 0, 0);      // reset lands on INIT edge 8
        tick();
        for (int k = 1; k <= 16; k++) begin
            apply(0, 1, 4'd15, 0, 0, 0, 0, 0);
            if (READY !== 1'b0) early = 1'b1;
            tick();
        end
        checks++;
        if (early) $display("FAIL rst_mid_ready: READY rose before 16 edges, expected 0");
        else passed++;
        apply(0, 1, 4'd15, 0, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (RVALID !== 1'b1 || RDATA !== 8'd15) $display("FAIL rst_mid_read15: got rvalid=%b rdata=%0h expected 1 f", RVALID, RDATA);
        else passed++;
        tick();
    endtask

    task automatic test_write_during_init();
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0, 1, 4'd3, 8'h55);
        checks++;
        if (WACK !== 1'b0) $display("FAIL init_wack: got %b expected 0", WACK);
        else passed++;
        tick();
        for (int k = 0; k < 20 && !m_ready; k++) begin
            apply(0, 0, 0, 0, 0, 1, 4'd3, 8'h55);
            tick();
        end
        apply(0, 1, 4'd3, 0, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (RVALID !== 1'b1 || RDATA !== 8'd3) $display("FAIL init_write_ignored: got rvalid=%b rdata=%0h expected 1 3", RVALID, RDATA);
        else passed++;
        tick();
    endtask

    task automatic test_random();
        bit p0 = 0, p1 = 0;
        logic [3:0] a0 = 0, a1 = 0;
        bit rst, w;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(0, 2) == 0) begin p0 = 1; a0 = 4'($urandom); end
            if (!p1 && $urandom_range(0, 2) == 0) begin p1 = 1; a1 = 4'($urandom); end
            if (p0 && $urandom_range(0, 19) == 0) p0 = 0;   // withdrawn request
            rst = ($urandom_range(0, 79) == 0);
            w   = ($urandom_range(0, 3) == 0);
            apply(rst, p0, a0, p1, a1, w, 4'($urandom), 8'($urandom));
            checks++;
            if ({READY, WACK, GNT0, GNT1} !== {m_ready, e_wack, e_g0, e_g1})
                $display("FAIL rand_ctrl[%0d]: got rdy/wack/g0/g1=%b expected %b", i, {READY, WACK, GNT0, GNT1}, {m_ready, e_wack, e_g0, e_g1});
            else passed++;
            checks++;
            if ({RVALID, RID, RDATA} !== {m_rvalid, m_rid, m_rdata})
                $display("FAIL rand_read[%0d]: got v/id/data=%b/%b/%0h expected %b/%b/%0h", i, RVALID, RID, RDATA, m_rvalid, m_rid, m_rdata);
            else passed++;
            if (e_g0 || rst) p0 = 0;
            if (e_g1 || rst) p1 = 0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_init_read();
        test_alternate();
        test_write_priority();
        test_reset_mid_init();
        test_write_during_init();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
